// File: rtl/panel_input.sv
// Front-panel button conditioning (2FF sync + debounce) and UI settings registers for the washer.
// Press-to-pulse latency is DEBOUNCE_CYCLES+2 cycles; outputs are registered and there is no backpressure.
module panel_input #(
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int LONG_PRESS_CYCLES = 100,
  parameter int CNT_W             = 8
) (
  input  logic       cp,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       powerBtn,
  input  logic       startBtn,
  input  logic       modeBtn,
  input  logic       weightBtn,
  output logic       powerPulse,
  output logic       startPulse,
  output logic       modePulse,
  output logic       weightPulse,
  output logic [2:0] weight,
  output logic [9:0] data
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);

  localparam int BTN_POWER  = 0;
  localparam int BTN_START  = 1;
  localparam int BTN_MODE   = 2;
  localparam int BTN_WEIGHT = 3;

  localparam logic [2:0] STATE_BEGIN   = 3'd1;
  localparam logic [2:0] STATE_SET     = 3'd2;
  localparam logic [2:0] MODE_LAST     = 3'd5;
  localparam logic [2:0] WEIGHT_MIN    = 3'd1;
  localparam logic [2:0] WEIGHT_MAX    = 3'd5;
  localparam logic [2:0] WEIGHT_INIT   = 3'd3;
  localparam logic [7:0] PROG_ALL_ON   = 8'hFF;

  logic [3:0]       rawBtn;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       db;
  logic [3:0]       dbQ;
  logic [3:0]       press;
  logic [CNT_W-1:0] dbCnt [4];
  logic [CNT_W-1:0] holdCnt;

  logic       powerOn;
  logic       setFlag;
  logic [2:0] mode;
  logic [7:0] programBits;

  logic       editable;
  logic       startAcc;
  logic       modeAcc;
  logic       weightAcc;
  logic       powerToggle;
  logic [2:0] nextMode;
  logic [2:0] nextWeight;

  function automatic logic [7:0] programTable(input logic [2:0] m);
    logic [7:0] bits;
    case (m)
      3'd0:    bits = 8'hFF;
      3'd1:    bits = 8'hC0;
      3'd2:    bits = 8'hFC;
      3'd3:    bits = 8'h3F;
      3'd4:    bits = 8'h3C;
      3'd5:    bits = 8'h03;
      default: bits = 8'hFF;
    endcase
    return bits;
  endfunction

  assign rawBtn = {weightBtn, modeBtn, startBtn, powerBtn};

  // Sync and debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      dbQ   <= '0;
      for (int i = 0; i < 4; i++) begin
        dbCnt[i] <= '0;
      end
    end else begin
      sync1 <= rawBtn;
      sync2 <= sync1;
      dbQ   <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DB_LAST) begin
          db[i]    <= sync2[i];
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
      end
    end
  end

  assign press       = db & ~dbQ;
  assign editable    = powerOn && ((state == STATE_BEGIN) || (state == STATE_SET));
  assign startAcc    = press[BTN_START] && powerOn;
  assign modeAcc     = press[BTN_MODE] && editable;
  assign weightAcc   = press[BTN_WEIGHT] && editable;
  assign powerToggle = db[BTN_POWER] && (holdCnt == HOLD_LAST);
  assign nextMode    = (mode == MODE_LAST) ? 3'd0 : mode + 3'd1;
  assign nextWeight  = (weight == WEIGHT_MAX) ? WEIGHT_MIN : weight + 3'd1;

  // Later assignments deliberately override earlier ones: start clears setFlag, power-off clears everything.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      holdCnt     <= '0;
      powerPulse  <= 1'b0;
      startPulse  <= 1'b0;
      modePulse   <= 1'b0;
      weightPulse <= 1'b0;
      powerOn     <= 1'b0;
      setFlag     <= 1'b0;
      mode        <= 3'd0;
      programBits <= PROG_ALL_ON;
      weight      <= WEIGHT_INIT;
    end else begin
      if (!db[BTN_POWER]) begin
        holdCnt <= '0;
      end else if (holdCnt != HOLD_MAX) begin
        holdCnt <= holdCnt + 1'b1;
      end

      powerPulse  <= powerToggle;
      startPulse  <= startAcc;
      modePulse   <= modeAcc;
      weightPulse <= weightAcc;

      if (modeAcc) begin
        mode        <= nextMode;
        programBits <= programTable(nextMode);
      end
      if (weightAcc) begin
        weight <= nextWeight;
      end
      if (modeAcc || weightAcc) begin
        setFlag <= 1'b1;
      end
      if (startAcc) begin
        setFlag <= 1'b0;
      end

      if (powerToggle) begin
        powerOn <= ~powerOn;
        if (powerOn) begin
          mode        <= 3'd0;
          programBits <= PROG_ALL_ON;
          weight      <= WEIGHT_INIT;
          setFlag     <= 1'b0;
        end
      end
    end
  end

  assign data = {setFlag, powerOn, programBits};

endmodule

// File: tb/tb_panel_input.sv
// Randomized scoreboard bench for panel_input: press-level reference model feeds an expected-event queue.
module tb_panel_input;

  localparam int D    = 20;
  localparam int LONG = 100;

  logic       cp = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       powerBtn, startBtn, modeBtn, weightBtn;
  logic       powerPulse, startPulse, modePulse, weightPulse;
  logic [2:0] weight;
  logic [9:0] data;

  panel_input #(
    .DEBOUNCE_CYCLES(D),
    .LONG_PRESS_CYCLES(LONG),
    .CNT_W(8)
  ) dut (
    .cp(cp),
    .rst(rst),
    .state(state),
    .powerBtn(powerBtn),
    .startBtn(startBtn),
    .modeBtn(modeBtn),
    .weightBtn(weightBtn),
    .powerPulse(powerPulse),
    .startPulse(startPulse),
    .modePulse(modePulse),
    .weightPulse(weightPulse),
    .weight(weight),
    .data(data)
  );

  always #5 cp = ~cp;

  int cyc = 0;
  always @(posedge cp) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;
    logic [2:0] weight;
    logic [9:0] data;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] progTab [6] = '{8'hFF, 8'hC0, 8'hFC, 8'h3F, 8'h3C, 8'h03};
  bit mPower = 0;
  bit mSet   = 0;
  int mMode  = 0;
  int mWeight = 3;

  int  errors = 0;
  int  checks = 0;
  bit  finishReq = 0;

  task automatic modelEvent(input int at, input bit pEv, input bit sEv, input bit mEv,
                            input bit wEv, input logic [2:0] st);
    bit sP, mP, wP;
    exp_t e;
    sP = sEv && mPower;
    mP = mEv && mPower && (st == 3'd1 || st == 3'd2);
    wP = wEv && mPower && (st == 3'd1 || st == 3'd2);
    if (mP) mMode = (mMode + 1) % 6;
    if (wP) mWeight = (mWeight % 5) + 1;
    if (mP || wP) mSet = 1;
    if (sP) mSet = 0;
    if (pEv) begin
      if (mPower) begin
        mPower = 0; mMode = 0; mWeight = 3; mSet = 0;
      end else begin
        mPower = 1;
      end
    end
    if (pEv || sP || mP || wP) begin
      e.cyc    = at;
      e.pulses = {wP, mP, sP, pEv};
      e.weight = 3'(mWeight);
      e.data   = {mSet, mPower, progTab[mMode]};
      sbq.push_back(e);
    end
  endtask

  task automatic setBtns(input logic [3:0] m);
    powerBtn  = m[0];
    startBtn  = m[1];
    modeBtn   = m[2];
    weightBtn = m[3];
  endtask

  // mask bits: 0 power, 1 start, 2 mode, 3 weight; all masked buttons held for len cycles.
  task automatic doPress(input logic [3:0] mask, input int len, input int gap);
    int k;
    @(negedge cp);
    k = cyc + 1;
    if (len >= D) begin
      if (mask[3:1] != 3'b000) modelEvent(k + D + 2, 0, mask[1], mask[2], mask[3], state);
      if (mask[0] && len >= LONG) modelEvent(k + D + 1 + LONG, 1, 0, 0, 0, state);
    end
    setBtns(mask);
    repeat (len) @(negedge cp);
    setBtns(4'b0000);
    repeat (gap) @(negedge cp);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [3:0] got;
  exp_t       e;

  always @(negedge cp) begin
    got = {weightPulse, modePulse, startPulse, powerPulse};
    if (rst) begin
      chk("rst_data", data, 10'h0FF);
      chk("rst_weight", weight, 3);
      chk("rst_pulses", got, 0);
    end else if (finishReq) begin
      chk("sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (got != 4'b0000) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", got, 0);
      end else begin
        e = sbq.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulses", got, e.pulses);
        chk("weight", weight, e.weight);
        chk("data", data, e.data);
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      chk("missing_pulse", 0, e.pulses);
    end
  end

  int kind;
  int len;
  int gap;

  initial begin
    rst = 1'b1;
    state = 3'd0;
    setBtns(4'b1111);
    repeat (4) @(negedge cp);
    rst = 1'b0;
    // Buttons held through reset look like fresh presses but must not toggle power or emit pulses.
    repeat (30) @(negedge cp);
    setBtns(4'b0000);
    repeat (40) @(negedge cp);

    doPress(4'b0001, 150, D + 8);            // power on
    state = 3'd2;
    doPress(4'b0100, D - 1, D + 8);          // glitch, ignored
    for (int i = 0; i < 6; i++) doPress(4'b0100, D, D + 8);
    state = 3'd3;
    doPress(4'b0100, D + 3, D + 8);          // not editable in run
    state = 3'd1;
    for (int i = 0; i < 3; i++) doPress(4'b1000, D + 2, D + 8);
    doPress(4'b0010, D + 4, D + 8);
    state = 3'd2;
    doPress(4'b1100, D + 1, D + 8);
    doPress(4'b0110, D + 1, D + 8);
    doPress(4'b0100, D + 1, D + 8);

    // Power-off on the same cycle as a mode event: power-off values must win.
    begin
      int k;
      @(negedge cp);
      k = cyc + 1;
      modelEvent(k + D + 1 + LONG, 1, 0, 1, 0, state);
      setBtns(4'b0001);
      repeat (LONG - 1) @(negedge cp);
      setBtns(4'b0101);
      repeat (D + 2) @(negedge cp);
      setBtns(4'b0001);
      repeat (150 - (LONG - 1) - (D + 2)) @(negedge cp);
      setBtns(4'b0000);
      repeat (D + 8) @(negedge cp);
    end

    doPress(4'b0010, D + 2, D + 8);          // start while off: no pulse
    doPress(4'b0001, 150, D + 8);            // power back on

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) state = 3'($urandom_range(1, 2));
      else state = 3'($urandom_range(0, 6));
      kind = $urandom_range(0, 9);
      len  = $urandom_range(D, D + 10);
      gap  = $urandom_range(D + 5, D + 15);
      case (kind)
        0, 1: doPress(4'b0100, len, gap);
        2, 3: doPress(4'b1000, len, gap);
        4:    doPress(4'b0010, len, gap);
        5:    doPress(4'b1100, len, gap);
        6:    doPress(4'b1010, len, gap);
        7:    doPress(4'(4'b0010 << $urandom_range(0, 2)), $urandom_range(1, D - 1), gap);
        8:    doPress(4'b0001, ($urandom_range(0, 1) == 1) ? 150 : $urandom_range(D, LONG - 10), gap);
        default: doPress(4'b1110, len, gap);
      endcase
    end

    repeat (10) @(negedge cp);
    finishReq = 1'b1;
  end

endmodule
